// File: rtl/mshr_coalescing.sv
// Coalescing miss status holding register for the data-cache miss path.
// Each entry tracks one outstanding cache line. Secondary misses to the same line
// are merged into that entry as extra targets. One fill request is issued per line,
// and every merged target is replayed in arrival order once the fill returns.
module mshr_coalescing #(
  parameter int unsigned NUM_ENTS    = 8,
  parameter int unsigned NUM_TARGETS = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINE_BYTES  = 32,
  parameter int unsigned ROB_ENTRIES = 64,
  parameter int unsigned ROB_IDX_W   = $clog2(ROB_ENTRIES),
  parameter int unsigned OFF_W       = $clog2(LINE_BYTES),
  parameter int unsigned ID_W        = $clog2(NUM_ENTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic                 alloc_is_store_i,
  input  logic [ADDR_W-1:0]    alloc_addr_i,
  input  logic [31:0]          alloc_data_i,
  input  logic [ROB_IDX_W-1:0] alloc_rob_idx_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic [ADDR_W-1:0]    mem_req_addr_o,
  output logic [ID_W-1:0]      mem_req_id_o,
  input  logic                 mem_resp_valid_i,
  input  logic [ID_W-1:0]      mem_resp_id_i,
  output logic                 replay_valid_o,
  input  logic                 replay_ready_i,
  output logic [ADDR_W-1:0]    replay_addr_o,
  output logic [31:0]          replay_data_o,
  output logic                 replay_is_store_o,
  output logic [ROB_IDX_W-1:0] replay_rob_idx_o,
  output logic [ID_W:0]        occupancy_o
);

  localparam int unsigned LINE_W = ADDR_W - OFF_W;
  localparam int unsigned CNT_W  = $clog2(NUM_TARGETS + 1);
  localparam int unsigned TI_W   = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAIT_ISSUE,
    ST_WAIT_FILL,
    ST_REPLAY
  } ent_st_e;

  ent_st_e                st_q    [NUM_ENTS];
  ent_st_e                st_d    [NUM_ENTS];
  logic [CNT_W-1:0]       cnt_q   [NUM_ENTS];
  logic [CNT_W-1:0]       cnt_d   [NUM_ENTS];
  logic [LINE_W-1:0]      line_q  [NUM_ENTS];
  logic [LINE_W-1:0]      line_d  [NUM_ENTS];
  logic [OFF_W-1:0]       t_off_q [NUM_ENTS][NUM_TARGETS];
  logic [OFF_W-1:0]       t_off_d [NUM_ENTS][NUM_TARGETS];
  logic                   t_st_q  [NUM_ENTS][NUM_TARGETS];
  logic                   t_st_d  [NUM_ENTS][NUM_TARGETS];
  logic [31:0]            t_data_q[NUM_ENTS][NUM_TARGETS];
  logic [31:0]            t_data_d[NUM_ENTS][NUM_TARGETS];
  logic [ROB_IDX_W-1:0]   t_rob_q [NUM_ENTS][NUM_TARGETS];
  logic [ROB_IDX_W-1:0]   t_rob_d [NUM_ENTS][NUM_TARGETS];

  logic                   req_lock_q, req_lock_d;
  logic [ID_W-1:0]        req_id_q, req_id_d;
  logic                   rep_lock_q, rep_lock_d;
  logic [ID_W-1:0]        rep_id_q, rep_id_d;
  logic [TI_W-1:0]        rep_ptr_q, rep_ptr_d;

  logic [LINE_W-1:0]      alloc_line;
  logic                   hit, hit_full, rep_hit, free_any;
  logic [ID_W-1:0]        hit_id, free_id;
  logic                   iss_found, rpl_found;
  logic [ID_W-1:0]        iss_id, rpl_id;
  logic                   req_hs, rep_hs, rep_last, alloc_fire;
  logic [ID_W-1:0]        tgt_ent;
  logic [TI_W-1:0]        tgt_idx;

  assign alloc_line = alloc_addr_i[ADDR_W-1:OFF_W];
  assign req_hs     = req_lock_q && mem_req_ready_i;
  assign rep_hs     = rep_lock_q && replay_ready_i;
  assign rep_last   = rep_hs && ((CNT_W'(rep_ptr_q) + CNT_W'(1)) == cnt_q[rep_id_q]);
  assign alloc_fire = alloc_valid_i && alloc_ready_o;

  // Line lookup for the incoming miss: merge hit, replay conflict and lowest free entry.
  always_comb begin
    hit      = 1'b0;
    hit_full = 1'b0;
    hit_id   = '0;
    rep_hit  = 1'b0;
    free_any = 1'b0;
    free_id  = '0;
    for (int unsigned i = 0; i < NUM_ENTS; i++) begin
      if ((st_q[i] == ST_WAIT_ISSUE || st_q[i] == ST_WAIT_FILL) && line_q[i] == alloc_line) begin
        hit      = 1'b1;
        hit_id   = ID_W'(i);
        hit_full = (cnt_q[i] == CNT_W'(NUM_TARGETS));
      end
      if (st_q[i] == ST_REPLAY && line_q[i] == alloc_line) rep_hit = 1'b1;
      if (st_q[i] == ST_FREE && !free_any) begin
        free_any = 1'b1;
        free_id  = ID_W'(i);
      end
    end
    if (hit)          alloc_ready_o = !hit_full;
    else if (rep_hit) alloc_ready_o = 1'b0;
    else              alloc_ready_o = free_any;
  end

  // Pick the next entry to issue and the next entry to replay. An entry whose lock is
  // being released this cycle is excluded so a successor can be locked without a gap.
  always_comb begin
    iss_found = 1'b0;
    iss_id    = '0;
    rpl_found = 1'b0;
    rpl_id    = '0;
    for (int unsigned i = 0; i < NUM_ENTS; i++) begin
      if (!iss_found && st_q[i] == ST_WAIT_ISSUE && !(req_hs && ID_W'(i) == req_id_q)) begin
        iss_found = 1'b1;
        iss_id    = ID_W'(i);
      end
      if (!rpl_found && st_q[i] == ST_REPLAY && !(rep_last && ID_W'(i) == rep_id_q)) begin
        rpl_found = 1'b1;
        rpl_id    = ID_W'(i);
      end
    end
  end

  // Next-state for entries, target storage and the issue/replay locks.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTS; i++) begin
      st_d[i]   = st_q[i];
      cnt_d[i]  = cnt_q[i];
      line_d[i] = line_q[i];
      for (int unsigned j = 0; j < NUM_TARGETS; j++) begin
        t_off_d[i][j]  = t_off_q[i][j];
        t_st_d[i][j]   = t_st_q[i][j];
        t_data_d[i][j] = t_data_q[i][j];
        t_rob_d[i][j]  = t_rob_q[i][j];
      end
    end
    req_lock_d = req_lock_q;
    req_id_d   = req_id_q;
    rep_lock_d = rep_lock_q;
    rep_id_d   = rep_id_q;
    rep_ptr_d  = rep_ptr_q;
    tgt_ent    = hit ? hit_id : free_id;
    tgt_idx    = hit ? TI_W'(cnt_q[hit_id]) : '0;

    if (req_hs) st_d[req_id_q] = ST_WAIT_FILL;
    if (mem_resp_valid_i && st_q[mem_resp_id_i] == ST_WAIT_FILL) st_d[mem_resp_id_i] = ST_REPLAY;
    if (rep_last) begin
      st_d[rep_id_q]  = ST_FREE;
      cnt_d[rep_id_q] = '0;
    end

    // Merge hits never target a REPLAY entry, so a merge can safely coincide with the
    // fill response of the same entry: the target lands before the replay starts.
    if (alloc_fire) begin
      if (hit) begin
        cnt_d[hit_id] = cnt_q[hit_id] + CNT_W'(1);
      end else begin
        st_d[free_id]   = ST_WAIT_ISSUE;
        line_d[free_id] = alloc_line;
        cnt_d[free_id]  = CNT_W'(1);
      end
      t_off_d[tgt_ent][tgt_idx]  = alloc_addr_i[OFF_W-1:0];
      t_st_d[tgt_ent][tgt_idx]   = alloc_is_store_i;
      t_data_d[tgt_ent][tgt_idx] = alloc_is_store_i ? alloc_data_i : '0;
      t_rob_d[tgt_ent][tgt_idx]  = alloc_rob_idx_i;
    end

    if (!req_lock_q || req_hs) begin
      req_lock_d = iss_found;
      if (iss_found) req_id_d = iss_id;
    end

    if (!rep_lock_q || rep_last) begin
      rep_lock_d = rpl_found;
      if (rpl_found) rep_id_d = rpl_id;
      rep_ptr_d = '0;
    end else if (rep_hs) begin
      rep_ptr_d = rep_ptr_q + TI_W'(1);
    end
  end

  // Entry state, target counts and locks; reset abandons all pending work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_ENTS; i++) begin
        st_q[i]  <= ST_FREE;
        cnt_q[i] <= '0;
      end
      req_lock_q <= 1'b0;
      req_id_q   <= '0;
      rep_lock_q <= 1'b0;
      rep_id_q   <= '0;
      rep_ptr_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      req_lock_q <= req_lock_d;
      req_id_q   <= req_id_d;
      rep_lock_q <= rep_lock_d;
      rep_id_q   <= rep_id_d;
      rep_ptr_q  <= rep_ptr_d;
    end
  end

  // Line address and target payload storage; only meaningful while the entry is live.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NUM_ENTS; i++) begin
      line_q[i] <= line_d[i];
      for (int unsigned j = 0; j < NUM_TARGETS; j++) begin
        t_off_q[i][j]  <= t_off_d[i][j];
        t_st_q[i][j]   <= t_st_d[i][j];
        t_data_q[i][j] <= t_data_d[i][j];
        t_rob_q[i][j]  <= t_rob_d[i][j];
      end
    end
  end

  // Count of live (non-free) entries.
  always_comb begin
    occupancy_o = '0;
    for (int unsigned i = 0; i < NUM_ENTS; i++) begin
      if (st_q[i] != ST_FREE) occupancy_o = occupancy_o + (ID_W+1)'(1);
    end
  end

  assign mem_req_valid_o   = req_lock_q;
  assign mem_req_id_o      = req_id_q;
  assign mem_req_addr_o    = {line_q[req_id_q], {OFF_W{1'b0}}};
  assign replay_valid_o    = rep_lock_q;
  assign replay_addr_o     = {line_q[rep_id_q], t_off_q[rep_id_q][rep_ptr_q]};
  assign replay_data_o     = t_data_q[rep_id_q][rep_ptr_q];
  assign replay_is_store_o = t_st_q[rep_id_q][rep_ptr_q];
  assign replay_rob_idx_o  = t_rob_q[rep_id_q][rep_ptr_q];

endmodule

// File: tb/tb_mshr_coalescing.sv
// Self-checking bench for mshr_coalescing: expected replays are queued when misses are
// driven and compared against the replay port as each handshake happens.
module tb_mshr_coalescing;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i, alloc_ready_o, alloc_is_store_i;
  logic [31:0] alloc_addr_i, alloc_data_i;
  logic [5:0]  alloc_rob_idx_i;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic [2:0]  mem_req_id_o;
  logic        mem_resp_valid_i;
  logic [2:0]  mem_resp_id_i;
  logic        replay_valid_o, replay_ready_i;
  logic [31:0] replay_addr_o, replay_data_o;
  logic        replay_is_store_o;
  logic [5:0]  replay_rob_idx_o;
  logic [3:0]  occupancy_o;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        st;
    logic [5:0]  rob;
  } rep_t;

  rep_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   rep_hs_cnt = 0;

  always #5 clk_i = ~clk_i;

  mshr_coalescing #(
    .NUM_ENTS(8), .NUM_TARGETS(4), .ADDR_W(32), .LINE_BYTES(32), .ROB_ENTRIES(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_is_store_i(alloc_is_store_i), .alloc_addr_i(alloc_addr_i),
    .alloc_data_i(alloc_data_i), .alloc_rob_idx_i(alloc_rob_idx_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_id_o(mem_req_id_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_id_i(mem_resp_id_i),
    .replay_valid_o(replay_valid_o), .replay_ready_i(replay_ready_i),
    .replay_addr_o(replay_addr_o), .replay_data_o(replay_data_o),
    .replay_is_store_o(replay_is_store_o), .replay_rob_idx_o(replay_rob_idx_o),
    .occupancy_o(occupancy_o)
  );

  // Scoreboard: every replay handshake must match the oldest expected target.
  always @(negedge clk_i) begin
    if (!rst_i && replay_valid_o && replay_ready_i) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL replay_unexpected: got addr=%h rob=%0d, required no replay", replay_addr_o, replay_rob_idx_o);
      end else begin
        if (replay_addr_o !== sb[0].addr || replay_data_o !== sb[0].data ||
            replay_is_store_o !== sb[0].st || replay_rob_idx_o !== sb[0].rob) begin
          fails++;
          $display("FAIL replay_payload: got addr=%h data=%h st=%b rob=%0d, required addr=%h data=%h st=%b rob=%0d",
                   replay_addr_o, replay_data_o, replay_is_store_o, replay_rob_idx_o,
                   sb[0].addr, sb[0].data, sb[0].st, sb[0].rob);
        end
        void'(sb.pop_front());
      end
      rep_hs_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish, required finish before 400us");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic rep_t mk(input logic st, input logic [31:0] addr, input logic [31:0] data, input logic [5:0] rob);
    rep_t e;
    e.addr = addr;
    e.data = st ? data : 32'h0;
    e.st   = st;
    e.rob  = rob;
    return e;
  endfunction

  task automatic do_alloc(input logic st, input logic [31:0] addr, input logic [31:0] data,
                          input logic [5:0] rob, input bit push, output bit ok);
    alloc_valid_i = 1'b1; alloc_is_store_i = st; alloc_addr_i = addr;
    alloc_data_i = data; alloc_rob_idx_i = rob;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk_i);
      if (alloc_ready_o === 1'b1) ok = 1'b1;
      tick();
    end
    alloc_valid_i = 1'b0;
    if (ok && push) sb.push_back(mk(st, addr, data, rob));
  endtask

  task automatic send_resp(input logic [2:0] id);
    mem_resp_valid_i = 1'b1; mem_resp_id_i = id;
    tick();
    mem_resp_valid_i = 1'b0;
  endtask

  task automatic wait_drain(output bit done);
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      tick();
      if (sb.size() == 0 && occupancy_o == 4'd0 && !replay_valid_o) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    alloc_addr_i = 32'h1234_5678;
    #1;
    tests++; if (mem_req_valid_o !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b required 0", mem_req_valid_o); end
    tests++; if (replay_valid_o !== 1'b0) begin fails++; $display("FAIL reset_replay_valid: got %b required 0", replay_valid_o); end
    tests++; if (occupancy_o !== 4'd0) begin fails++; $display("FAIL reset_occupancy: got %0d required 0", occupancy_o); end
    tests++; if (alloc_ready_o !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready: got %b required 1", alloc_ready_o); end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok, done;
    do_alloc(1'b0, 32'h1000_0044, 32'hFFFF_FFFF, 6'd3, 1'b1, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_alloc_ready: got 0 required 1"); end
    tests++; if (mem_req_valid_o !== 1'b0) begin fails++; $display("FAIL single_req_early: got %b required 0", mem_req_valid_o); end
    tests++; if (occupancy_o !== 4'd1) begin fails++; $display("FAIL single_occ: got %0d required 1", occupancy_o); end
    tick();
    tests++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h1000_0040 || mem_req_id_o !== 3'd0) begin
      fails++; $display("FAIL single_req: got v=%b addr=%h id=%0d required v=1 addr=10000040 id=0", mem_req_valid_o, mem_req_addr_o, mem_req_id_o);
    end
    mem_req_ready_i = 1'b1;
    tick();
    mem_req_ready_i = 1'b0;
    tests++; if (mem_req_valid_o !== 1'b0) begin fails++; $display("FAIL single_req_drop: got %b required 0", mem_req_valid_o); end
    send_resp(3'd0);
    wait_drain(done);
    tests++; if (!done) begin fails++; $display("FAIL single_drain: got occ=%0d pending=%0d required 0 0", occupancy_o, sb.size()); end
  endtask

  task automatic test_coalesce();
    bit ok0, ok1, ok2, done;
    int n, id;
    bit seen[12];
    int first, last, total;
    mem_req_ready_i = 1'b0;
    do_alloc(1'b0, 32'h2000_0000, 32'h0, 6'd1, 1'b1, ok0);
    do_alloc(1'b1, 32'h2000_0008, 32'hDEAD_BEEF, 6'd2, 1'b1, ok1);
    do_alloc(1'b0, 32'h2000_001C, 32'h0, 6'd4, 1'b1, ok2);
    tests++; if (!(ok0 && ok1 && ok2)) begin fails++; $display("FAIL coal_alloc: got %b%b%b required 111", ok0, ok1, ok2); end
    tests++; if (occupancy_o !== 4'd1) begin fails++; $display("FAIL coal_occ: got %0d required 1", occupancy_o); end
    mem_req_ready_i = 1'b1;
    n = 0; id = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (mem_req_valid_o) begin n++; id = int'(mem_req_id_o); end
      tick();
    end
    mem_req_ready_i = 1'b0;
    tests++; if (n != 1 || id != 0) begin fails++; $display("FAIL coal_one_req: got count=%0d id=%0d required count=1 id=0", n, id); end
    send_resp(3'd0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      seen[k] = replay_valid_o;
      tick();
    end
    first = -1; last = -1; total = 0;
    for (int k = 0; k < 12; k++) if (seen[k]) begin if (first < 0) first = k; last = k; total++; end
    tests++; if (total != 3 || (last - first + 1) != 3) begin fails++; $display("FAIL coal_back_to_back: got %0d replays over %0d cycles required 3 over 3", total, last - first + 1); end
    wait_drain(done);
    tests++; if (!done) begin fails++; $display("FAIL coal_drain: got occ=%0d pending=%0d required 0 0", occupancy_o, sb.size()); end
  endtask

  task automatic test_overflow();
    bit ok, okb, acc, done, expr;
    int ids[$];
    int base, c0;
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_alloc(1'b0, 32'h3000_0000 + 32'(i * 4), 32'h0, 6'(10 + i), 1'b1, ok);
      tests++; if (!ok) begin fails++; $display("FAIL ovf_merge_%0d: got 0 required 1", i); end
    end
    alloc_valid_i = 1'b1; alloc_is_store_i = 1'b1; alloc_addr_i = 32'h3000_0010;
    alloc_data_i = 32'h1234_5678; alloc_rob_idx_i = 6'd14;
    @(negedge clk_i);
    tests++; if (alloc_ready_o !== 1'b0) begin fails++; $display("FAIL ovf_full_stall: got %b required 0", alloc_ready_o); end
    tick();
    alloc_valid_i = 1'b0;
    do_alloc(1'b0, 32'h4000_0000, 32'h0, 6'd20, 1'b1, okb);
    tests++; if (!okb) begin fails++; $display("FAIL ovf_other_line: got 0 required 1"); end
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (mem_req_valid_o) ids.push_back(int'(mem_req_id_o));
      tick();
    end
    mem_req_ready_i = 1'b0;
    tests++;
    if (ids.size() != 2 || ids[0] != 0 || ids[1] != 1) begin
      fails++; $display("FAIL ovf_issue_ids: got %0d requests required ids 0,1", ids.size());
    end
    base = rep_hs_cnt;
    alloc_valid_i = 1'b1; alloc_is_store_i = 1'b1; alloc_addr_i = 32'h3000_0010;
    alloc_data_i = 32'h1234_5678; alloc_rob_idx_i = 6'd14;
    mem_resp_valid_i = 1'b1; mem_resp_id_i = 3'd0;
    acc = 1'b0;
    for (int k = 0; k < 30 && !acc; k++) begin
      c0 = rep_hs_cnt;
      @(negedge clk_i);
      expr = (c0 >= base + 4);
      tests++;
      if (alloc_ready_o !== expr) begin fails++; $display("FAIL ovf_ready_until_drain: got %b required %b", alloc_ready_o, expr); end
      if (alloc_ready_o === 1'b1) acc = 1'b1;
      tick();
      mem_resp_valid_i = 1'b0;
    end
    alloc_valid_i = 1'b0;
    tests++; if (!acc) begin fails++; $display("FAIL ovf_accept_after_drain: got 0 required 1"); end
    if (acc) sb.push_back(mk(1'b1, 32'h3000_0010, 32'h1234_5678, 6'd14));
    send_resp(3'd1);
    mem_req_ready_i = 1'b1;
    ids.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (mem_req_valid_o) ids.push_back(int'(mem_req_id_o));
      tick();
    end
    mem_req_ready_i = 1'b0;
    tests++; if (ids.size() != 1 || ids[0] != 0) begin fails++; $display("FAIL ovf_realloc_id: got %0d requests required one for id 0", ids.size()); end
    send_resp(3'd0);
    wait_drain(done);
    tests++; if (!done) begin fails++; $display("FAIL ovf_drain: got occ=%0d pending=%0d required 0 0", occupancy_o, sb.size()); end
  endtask

  task automatic test_full();
    bit ok, all_ok, done;
    int ids[$];
    mem_req_ready_i = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_alloc(1'(i % 2), 32'h5000_0000 + 32'(i * 32 + i * 4), 32'hA0 + 32'(i), 6'(30 + i), 1'b1, ok);
      all_ok &= ok;
    end
    tests++; if (!all_ok) begin fails++; $display("FAIL full_allocs: got a refused alloc required 8 accepted"); end
    alloc_addr_i = 32'h6000_0000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      tests++;
      if (alloc_ready_o !== 1'b0 || occupancy_o !== 4'd8 || mem_req_valid_o !== 1'b1 || mem_req_id_o !== 3'd0) begin
        fails++; $display("FAIL full_hold: got ready=%b occ=%0d v=%b id=%0d required 0 8 1 0", alloc_ready_o, occupancy_o, mem_req_valid_o, mem_req_id_o);
      end
      tick();
    end
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (mem_req_valid_o) ids.push_back(int'(mem_req_id_o));
      tick();
    end
    mem_req_ready_i = 1'b0;
    tests++; if (ids.size() != 8) begin fails++; $display("FAIL full_issue_count: got %0d required 8", ids.size()); end
    for (int i = 0; i < ids.size() && i < 8; i++) begin
      tests++; if (ids[i] != i) begin fails++; $display("FAIL full_issue_order: got id %0d required %0d", ids[i], i); end
    end
    for (int i = 0; i < 8; i++) send_resp(3'(i));
    wait_drain(done);
    tests++; if (!done) begin fails++; $display("FAIL full_drain: got occ=%0d pending=%0d required 0 0", occupancy_o, sb.size()); end
  endtask

  task automatic test_ooo_fill();
    bit ok, all_ok, found, done, empty;
    mem_req_ready_i = 1'b0;
    all_ok = 1'b1;
    do_alloc(1'b0, 32'h7000_0000, 32'h0, 6'd40, 1'b0, ok); all_ok &= ok;
    do_alloc(1'b0, 32'h7000_0100, 32'h0, 6'd41, 1'b0, ok); all_ok &= ok;
    do_alloc(1'b0, 32'h7000_0200, 32'h0, 6'd42, 1'b0, ok); all_ok &= ok;
    do_alloc(1'b1, 32'h7000_0204, 32'hCAFE_0001, 6'd43, 1'b0, ok); all_ok &= ok;
    tests++; if (!all_ok) begin fails++; $display("FAIL ooo_allocs: got a refused alloc required all accepted"); end
    mem_req_ready_i = 1'b1;
    repeat (5) tick();
    mem_req_ready_i = 1'b0;
    replay_ready_i = 1'b0;
    send_resp(3'd5);
    tick();
    tests++;
    if (occupancy_o !== 4'd3 || replay_valid_o !== 1'b0) begin
      fails++; $display("FAIL ooo_spurious: got occ=%0d rv=%b required 3 0", occupancy_o, replay_valid_o);
    end
    sb.push_back(mk(1'b0, 32'h7000_0200, 32'h0, 6'd42));
    sb.push_back(mk(1'b1, 32'h7000_0204, 32'hCAFE_0001, 6'd43));
    sb.push_back(mk(1'b0, 32'h7000_0000, 32'h0, 6'd40));
    send_resp(3'd2);
    send_resp(3'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk_i);
      if (replay_valid_o) found = 1'b1;
      tick();
    end
    tests++; if (!found) begin fails++; $display("FAIL ooo_replay_start: got no replay required one"); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      tests++;
      if (replay_valid_o !== 1'b1 || replay_addr_o !== sb[0].addr || replay_rob_idx_o !== sb[0].rob ||
          replay_data_o !== sb[0].data || replay_is_store_o !== sb[0].st) begin
        fails++; $display("FAIL ooo_stall_hold: got v=%b addr=%h rob=%0d required v=1 addr=%h rob=%0d",
                          replay_valid_o, replay_addr_o, replay_rob_idx_o, sb[0].addr, sb[0].rob);
      end
      tick();
    end
    replay_ready_i = 1'b1;
    empty = 1'b0;
    for (int k = 0; k < 20 && !empty; k++) begin
      tick();
      if (sb.size() == 0) empty = 1'b1;
    end
    tests++; if (!empty) begin fails++; $display("FAIL ooo_order_drain: got %0d pending required 0", sb.size()); end
    tests++; if (occupancy_o !== 4'd1) begin fails++; $display("FAIL ooo_occ_left: got %0d required 1", occupancy_o); end
    sb.push_back(mk(1'b0, 32'h7000_0100, 32'h0, 6'd41));
    send_resp(3'd1);
    wait_drain(done);
    tests++; if (!done) begin fails++; $display("FAIL ooo_drain: got occ=%0d pending=%0d required 0 0", occupancy_o, sb.size()); end
  endtask

  task automatic test_reset_mid_replay();
    bit ok, all_ok, found;
    mem_req_ready_i = 1'b0;
    all_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_alloc(1'b0, 32'h8000_0000 + 32'(i * 8), 32'h0, 6'(50 + i), 1'b1, ok);
      all_ok &= ok;
    end
    tests++; if (!all_ok) begin fails++; $display("FAIL rst_allocs: got a refused alloc required all accepted"); end
    mem_req_ready_i = 1'b1;
    repeat (4) tick();
    mem_req_ready_i = 1'b0;
    replay_ready_i = 1'b0;
    send_resp(3'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk_i);
      if (replay_valid_o) found = 1'b1;
      tick();
    end
    tests++; if (!found) begin fails++; $display("FAIL rst_replay_start: got no replay required one"); end
    replay_ready_i = 1'b1;
    tick();
    replay_ready_i = 1'b0;
    tests++; if (sb.size() != 2) begin fails++; $display("FAIL rst_one_drained: got %0d pending required 2", sb.size()); end
    #2;
    rst_i = 1'b1;
    #1;
    tests++;
    if (replay_valid_o !== 1'b0 || occupancy_o !== 4'd0 || mem_req_valid_o !== 1'b0) begin
      fails++; $display("FAIL rst_async_clear: got rv=%b occ=%0d mv=%b required 0 0 0", replay_valid_o, occupancy_o, mem_req_valid_o);
    end
    sb.delete();
    tick();
    rst_i = 1'b0;
    replay_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      tests++; if (replay_valid_o !== 1'b0) begin fails++; $display("FAIL rst_no_replay: got %b required 0", replay_valid_o); end
      tick();
    end
    tests++; if (alloc_ready_o !== 1'b1 || occupancy_o !== 4'd0) begin fails++; $display("FAIL rst_after: got ready=%b occ=%0d required 1 0", alloc_ready_o, occupancy_o); end
  endtask

  initial begin
    rst_i = 1'b1;
    alloc_valid_i = 1'b0; alloc_is_store_i = 1'b0; alloc_addr_i = '0;
    alloc_data_i = '0; alloc_rob_idx_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_id_i = '0;
    replay_ready_i = 1'b1;
    test_reset();
    test_single();
    test_coalesce();
    test_overflow();
    test_full();
    test_ooo_fill();
    test_reset_mid_replay();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mshr_coalescing.md
Name: mshr_coalescing

Overview:
- Next-generation miss status holding register for the data-cache miss path. It sits between the LSU miss port and the memory/fill interface.
- Tracks misses per cache line rather than per access. A secondary miss to a line that is already outstanding merges into that line's entry instead of spending a new one.
- Issues one fill request per line, accepts fill responses by entry ID, and replays every merged load/store target to the LSU in arrival order.
- Entry count, target depth, address width and line size are all parametrised.

Parameters:
- NUM_ENTS, 8, number of line entries; power of two, ≥2.
- NUM_TARGETS, 4, maximum merged accesses per entry; ≥1.
- ADDR_W, 32, byte address width.
- LINE_BYTES, 32, cache line size in bytes; power of two. OFF_W = $clog2(LINE_BYTES).
- ROB_IDX_W, $clog2(ROB_ENTRIES), ROB index width.
- Derived: ID_W = $clog2(NUM_ENTS).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- alloc_valid_i  in  1  miss presented by LSU
- alloc_ready_o  out  1  miss accepted this cycle when valid&ready
- alloc_is_store_i  in  1  1 = store miss, 0 = load miss
- alloc_addr_i  in  ADDR_W  byte address of the access
- alloc_data_i  in  32  store data; ignored for loads
- alloc_rob_idx_i  in  ROB_IDX_W  ROB index of the access
- mem_req_valid_o  out  1  fill request valid
- mem_req_ready_i  in  1  memory accepts the request
- mem_req_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits = 0)
- mem_req_id_o  out  ID_W  entry ID of the request
- mem_resp_valid_i  in  1  fill complete
- mem_resp_id_i  in  ID_W  entry ID being completed
- replay_valid_o  out  1  target replay valid
- replay_ready_i  in  1  LSU consumes the replay
- replay_addr_o  out  ADDR_W  full byte address of the target
- replay_data_o  out  32  store data (0 for loads)
- replay_is_store_o  out  1  target type
- replay_rob_idx_o  out  ROB_IDX_W  target ROB index
- occupancy_o  out  ID_W+1  number of non-FREE entries

Behaviour:
- Reset (async, rst_i=1):
  - All entries FREE and all target counts 0; request and replay locks cleared.
  - mem_req_valid_o=0, replay_valid_o=0, occupancy_o=0, alloc_ready_o=1.
  - A reset mid-operation drops all pending misses and handshakes without emitting anything.
- Entry states: FREE → WAIT_ISSUE (allocated) → WAIT_FILL (request handshaked) → REPLAY (response received) → FREE (last target handshaked).
- Line match: an entry matches when its line address equals alloc_addr_i[ADDR_W-1:OFF_W] and its state is WAIT_ISSUE or WAIT_FILL.
- alloc_ready_o is combinational from state and alloc_addr_i only; it never depends on alloc_valid_i. It is:
  - 1 if a match exists and that entry's target count < NUM_TARGETS (merge);
  - 0 if a match exists and the entry is full (stall; no second entry for the same line);
  - 0 if any REPLAY entry holds the same line (stall until drained);
  - otherwise 1 if any entry is FREE (allocate the lowest-index FREE entry), else 0.
- Merge: the target is appended at position count and count increments. Targets are kept in FIFO order per entry.
- Allocate: the entry captures the line address, target 0 and count=1, and enters WAIT_ISSUE on the next edge.
- Issue:
  - When no request is locked, the lowest-index WAIT_ISSUE entry is selected and locked. mem_req_valid_o rises in the cycle after the entry enters WAIT_ISSUE.
  - mem_req_addr_o and mem_req_id_o are held stable while valid and not ready.
  - On handshake the entry moves to WAIT_FILL and the lock is released; the next request can be presented the following cycle.
- Response: mem_resp_valid_i with an ID in WAIT_FILL moves that entry to REPLAY on the next edge. A response to an ID not in WAIT_FILL is ignored.
- Merge at fill: a merge into an entry in the same cycle its response arrives is accepted, and the target is replayed.
- Replay:
  - The lowest-index REPLAY entry is locked until all its targets have drained.
  - Targets are presented in arrival order, one per replay_valid_o&replay_ready_i handshake, with payload stable while stalled.
  - The handshake of the last target frees the entry on that edge; it is allocatable the next cycle.
  - There is no bubble between consecutive targets of the same entry.
- Simultaneous events: alloc, issue handshake, response and replay handshake may all occur in one cycle on different entries. Each applies independently, and occupancy_o reflects every one of them on the next edge.

Test Plan:
- Reset, then load 0x1000_0044 rob 3 → alloc_ready_o=1; next cycle mem_req_valid_o=1, addr 0x1000_0040, id 0. With ready=1 then resp id 0 → replay addr 0x1000_0044, rob 3, is_store=0; entry freed, occupancy_o back to 0.
- Coalescing: load 0x2000_0000 rob 1, store 0x2000_0008 data 0xDEADBEEF rob 2, load 0x2000_001C rob 4 before the response → exactly one mem request. After the response, replays come out rob 1, 2 (data 0xDEADBEEF), 4 in that order with replay_ready_i=1 every cycle, occupying 3 consecutive cycles.
- Target overflow with NUM_TARGETS=4: a 5th miss to the same pending line → alloc_ready_o=0 until the entry drains. Meanwhile a miss to a different line is accepted into entry 1.
- Full: 8 distinct lines allocated with mem_req_ready_i=0 → alloc_ready_o=0, occupancy_o=8, mem_req_id_o held at 0. Raising ready issues IDs 0..7 in order.
- Out-of-order fill: responses for id 2 then id 0, plus a spurious response for FREE id 5 → entry 2 replays first, then entry 0; id 5 has no effect. A replay stall (replay_ready_i=0 for 3 cycles) holds the payload unchanged.
- Async reset asserted mid-replay with 2 targets remaining → replay_valid_o=0 immediately, occupancy_o=0, and no further replays after reset deasserts.
